game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Generates the snake game's step ticks. A fixed prescaler produces a millisecond strobe. A programmable period counter then issues one game tick every N strobes, where N is set by the current speed level.
- Sequences start, pause and stop of the game clock.
- Delivers each tick to the game-logic FSM over a req/ack handshake and counts ticks the game logic missed.
- Sits between the system clock domain and the snake update logic, replacing ad-hoc fixed dividers.

Parameters:
- PRESCALE, 25000, clk cycles per ms strobe (25 MHz pixel clock -> 1 kHz)
- BASE_PERIOD, 250, tick period in ms strobes at speed 0
- STEP, 25, ms strobes removed from the period per speed level
- MIN_PERIOD, 50, floor on the tick period in ms strobes; must be >= 1
- PW, 9, width of the period counter and latched period; must hold BASE_PERIOD

Ports:
- clk, in, 1, system clock; all state changes on rising edge
- reset, in, 1, asynchronous active-low reset
- start, in, 1, level-sampled; IDLE -> RUN
- stop, in, 1, level-sampled; any state -> IDLE
- pause, in, 1, level; high holds the timebase in PAUSE
- speed, in, 3, speed level 0..7; sampled only at period boundaries and on start
- tick_ack, in, 1, game logic has consumed the pending tick
- clear_overrun, in, 1, synchronous clear of overrun_cnt
- tick_req, out, 1, a tick is pending
- running, out, 1, high in RUN or PAUSE
- paused, out, 1, high in PAUSE
- overrun_cnt, out, 8, saturating count of ticks dropped while tick_req was already high

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; tick_req, running, paused, overrun_cnt = 0
  - prescaler = 0, pcnt = 0, period_q = BASE_PERIOD
- Period function: period(s) = BASE_PERIOD - s*STEP if s*STEP <= BASE_PERIOD - MIN_PERIOD, else MIN_PERIOD.
  - Compare in unsigned arithmetic wide enough that the result never wraps negative.
- States:
  - IDLE: prescaler and pcnt held at 0. start=1 -> RUN; in the same edge, period_q <= period(speed), prescaler and pcnt cleared.
  - RUN: the prescaler counts 0..PRESCALE-1 and wraps. ms strobe = (prescaler == PRESCALE-1). On a strobe, pcnt increments.
  - Period boundary: strobe and pcnt == period_q-1. At the boundary, pcnt <= 0, period_q <= period(speed), and a tick event fires.
  - RUN, pause=1 -> PAUSE.
  - PAUSE: prescaler and pcnt frozen, no strobes, no tick events. pause=0 -> RUN, resuming from the frozen counts.
  - start while in RUN or PAUSE is ignored.
- Priority: stop > start/pause. stop=1 in any state -> IDLE, clears tick_req, prescaler and pcnt. overrun_cnt is preserved.
- Timing: the first tick event occurs exactly PRESCALE*period_q clk edges after the edge that entered RUN. Paused cycles add to this one-for-one.
- Handshake:
  - Tick event with tick_req=0 -> tick_req <= 1 on that edge.
  - tick_req=1 and tick_ack=1 sampled, no coincident tick event -> tick_req <= 0.
  - Tick event and tick_ack=1 on the same edge while tick_req=1: the ack consumes the old tick, the event supplies a new one. tick_req stays 1, no overrun.
  - Tick event, tick_req=1, tick_ack=0 -> tick dropped, overrun_cnt += 1, saturating at 255.
  - tick_ack while tick_req=0 is ignored.
  - tick_req remains held through PAUSE, and acks are honoured in PAUSE.
- clear_overrun: overrun_cnt <= 0. It takes priority over a coincident increment.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan (PRESCALE=4, BASE_PERIOD=10, STEP=2, MIN_PERIOD=3):
- Reset, speed=0, pulse start one cycle, ack 2 cycles after each req -> tick_req rises 40 edges after the start edge, then every 40 edges; overrun_cnt=0.
- speed=7 during the first period -> the first tick still arrives at 40; subsequent periods are 12 clocks (clamp: 14 > 7 -> MIN_PERIOD 3); speed=3 -> 16 clocks.
- Never ack -> tick_req stays 1; overrun_cnt counts 1, 2, ... every period; saturates at 255 and does not wrap; clear_overrun -> 0.
- Ack asserted on the exact boundary edge with tick_req=1 -> tick_req stays 1 continuously and overrun_cnt is unchanged.
- pause=1 for 17 cycles mid-period -> the next tick is delayed exactly 17 cycles; a pending req acked in PAUSE drops.
- stop and pause together during RUN -> IDLE, tick_req=0, running=0, overrun_cnt retained. Async reset asserted mid-period -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: ms prescaler plus speed-dependent period counter that issues
// snake game ticks over a req/ack handshake, with start/pause/stop sequencing.
module game_tick_scheduler #(
    parameter int PRESCALE    = 25000,
    parameter int BASE_PERIOD = 250,
    parameter int STEP        = 25,
    parameter int MIN_PERIOD  = 50,
    parameter int PW          = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [2:0] speed,
    input  logic       tick_ack,
    input  logic       clear_overrun,
    output logic       tick_req,
    output logic       running,
    output logic       paused,
    output logic [7:0] overrun_cnt
);
    localparam int PSW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t         state, state_nx;
    logic [PSW-1:0] prescaler;
    logic [PW-1:0]  pcnt, period_q;
    logic           strobe, boundary, tick_evt;

    // 32-bit unsigned compare keeps large speed*STEP from wrapping below the floor
    function automatic logic [PW-1:0] period_of(input logic [2:0] s);
        logic [31:0] d;
        d = 32'(s) * 32'(STEP);
        return (d <= 32'(BASE_PERIOD - MIN_PERIOD)) ? PW'(32'(BASE_PERIOD) - d) : PW'(MIN_PERIOD);
    endfunction

    always_comb begin
        state_nx = stop                        ? IDLE  :
                   (state == IDLE  && start)   ? RUN   :
                   (state == RUN   && pause)   ? PAUSE :
                   (state == PAUSE && !pause)  ? RUN   : state;
        strobe   = (state == RUN) && (prescaler == PSW'(PRESCALE - 1));
        boundary = strobe && (pcnt == period_q - PW'(1));
        tick_evt = boundary && !stop;
    end

    assign running = (state != IDLE);
    assign paused  = (state == PAUSE);

    // The edge that samples pause in RUN still counts, so PAUSE freezes exactly the paused cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prescaler <= '0;
            pcnt      <= '0;
            period_q  <= PW'(BASE_PERIOD);
        end else begin
            state <= state_nx;
            if (stop || state == IDLE) begin
                prescaler <= '0;
                pcnt      <= '0;
            end else if (state == RUN) begin
                prescaler <= strobe ? '0 : prescaler + 1'b1;
                if (strobe)
                    pcnt <= boundary ? '0 : pcnt + 1'b1;
            end
            if (!stop && ((state == IDLE && start) || boundary))
                period_q <= period_of(speed);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_req    <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            tick_req <= stop     ? 1'b0 :
                        tick_evt ? 1'b1 :
                        tick_ack ? 1'b0 : tick_req;
            if (clear_overrun)
                overrun_cnt <= '0;
            else if (tick_evt && tick_req && !tick_ack && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed checks of tick timing, speed clamp, handshake,
// overrun saturation, pause, stop and async reset with a small prescaler.
module tb_game_tick_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       tick_ack = 1'b0, clear_overrun = 1'b0;
    logic       tick_req, running, paused;
    logic [7:0] overrun_cnt;
    int         total = 0, bad = 0;
    int         cyc = 0;
    int         t0, t;

    game_tick_scheduler #(
        .PRESCALE(4), .BASE_PERIOD(10), .STEP(2), .MIN_PERIOD(3), .PW(9)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .speed(speed), .tick_ack(tick_ack), .clear_overrun(clear_overrun),
        .tick_req(tick_req), .running(running), .paused(paused), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input int lim, output int when);
        int n = 0;
        while (!tick_req && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!tick_req) chk("wait_req_timeout", tick_req, 1);
        when = cyc;
    endtask

    task automatic ack_now;
        step(1);
        tick_ack = 1'b1;
        step(1);
        tick_ack = 1'b0;
    endtask

    task automatic go;
        start = 1'b1;
        step(1);
        start = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        step(2);
        chk("rst_req", tick_req, 0);
        chk("rst_running", running, 0);
        chk("rst_paused", paused, 0);
        chk("rst_ovr", overrun_cnt, 0);
        reset = 1'b1;
        step(1);

        // speed 0: ticks every 40 edges
        go();
        wait_req(100, t);
        chk("s0_first", t - t0, 40);
        ack_now();
        chk("s0_ack_drop", tick_req, 0);
        wait_req(100, t);
        chk("s0_second", t - t0, 80);
        chk("s0_ovr", overrun_cnt, 0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_req", tick_req, 0);
        chk("stop_running", running, 0);

        // speed change mid-period takes effect only at the boundary
        go();
        step(1);
        speed = 3'd7;
        wait_req(100, t);
        chk("spd_first", t - t0, 40);
        ack_now();
        wait_req(100, t);
        chk("spd7_clamp", t - t0, 52);
        ack_now();
        speed = 3'd3;
        wait_req(100, t);
        chk("spd3_latch", t - t0, 64);
        ack_now();
        wait_req(100, t);
        chk("spd3_period", t - t0, 80);

        // never ack: overrun counts per period and saturates
        speed = 3'd7;
        step(16);
        chk("ovr_1", overrun_cnt, 1);
        chk("ovr_req_held", tick_req, 1);
        step(12);
        chk("ovr_2", overrun_cnt, 2);
        step(3200);
        chk("ovr_sat", overrun_cnt, 255);
        chk("ovr_sat_req", tick_req, 1);
        stop = 1'b1;
        clear_overrun = 1'b1;
        step(1);
        stop = 1'b0;
        clear_overrun = 1'b0;
        chk("clr_ovr", overrun_cnt, 0);
        chk("clr_req", tick_req, 0);

        // ack on the boundary edge: req stays high, no overrun
        go();
        wait_req(100, t);
        chk("bnd_first", t - t0, 12);
        step(11);
        chk("bnd_pre_req", tick_req, 1);
        tick_ack = 1'b1;
        step(1);
        tick_ack = 1'b0;
        chk("bnd_req", tick_req, 1);
        chk("bnd_ovr", overrun_cnt, 0);
        step(1);
        chk("bnd_req_after", tick_req, 1);
        step(11);
        chk("bnd_noack_ovr", overrun_cnt, 1);

        // 17 paused cycles delay the next tick by 17; ack honoured in PAUSE
        step(1);
        pause = 1'b1;
        step(2);
        chk("pz_paused", paused, 1);
        chk("pz_running", running, 1);
        chk("pz_req", tick_req, 1);
        tick_ack = 1'b1;
        step(1);
        tick_ack = 1'b0;
        chk("pz_ack_drop", tick_req, 0);
        step(14);
        pause = 1'b0;
        step(1);
        chk("pz_resumed", paused, 0);
        wait_req(100, t);
        chk("pz_delay", t - t0, 65);
        chk("pz_ovr", overrun_cnt, 1);

        // stop beats pause; overrun retained
        step(3);
        stop = 1'b1;
        pause = 1'b1;
        step(1);
        stop = 1'b0;
        pause = 1'b0;
        chk("sp_running", running, 0);
        chk("sp_paused", paused, 0);
        chk("sp_req", tick_req, 0);
        chk("sp_ovr", overrun_cnt, 1);

        // async reset clears outputs with no clock edge
        go();
        wait_req(100, t);
        chk("ar_first", t - t0, 12);
        #2 reset = 1'b0;
        #1;
        chk("ar_req", tick_req, 0);
        chk("ar_running", running, 0);
        chk("ar_paused", paused, 0);
        chk("ar_ovr", overrun_cnt, 0);
        step(1);
        reset = 1'b1;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
